// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder: WIDTH bits split into CHUNK-bit slices, one slice per stage.
// Optional subtract mode (sub port) is built when PIPE_ADDSUB_SUB_EN is defined.
module pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef PIPE_ADDSUB_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow
);

    localparam int unsigned NS = WIDTH / CHUNK;
    localparam int unsigned CW = CHUNK + 1;

    // Stage chain: index k is the input of stage k, index k+1 its registered output.
    // m_c holds the operand-A word shifted right one chunk per stage, with finished
    // sum chunks entering at the top, so after NS stages it is the full aligned sum.
    logic [WIDTH-1:0] m_c [NS+1];
    logic [WIDTH-1:0] b_c [NS];
    logic             c_c [NS+1];
    logic             v_c [NS+1];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is folded in as A + ~B + 1 before the first slice.
`ifdef PIPE_ADDSUB_SUB_EN
    assign b_eff = sub ? ~B : B;
    assign c_eff = sub | Cin;
`else
    assign b_eff = B;
    assign c_eff = Cin;
`endif

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    assign m_c[0] = A;
    assign b_c[0] = b_eff;
    assign c_c[0] = c_eff;
    assign v_c[0] = in_valid;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        logic [CW-1:0]    ext;
        logic [WIDTH-1:0] m_q;
        logic             c_q;
        logic             v_q;

        assign ext = CW'(m_c[k][CHUNK-1:0]) + CW'(b_c[k][CHUNK-1:0]) + CW'(c_c[k]);

        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                m_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                m_q <= (m_c[k] >> CHUNK) | (WIDTH'(ext[CHUNK-1:0]) << (WIDTH - CHUNK));
                c_q <= ext[CHUNK];
                v_q <= v_c[k];
            end
        end

        assign m_c[k+1] = m_q;
        assign c_c[k+1] = c_q;
        assign v_c[k+1] = v_q;

        // Remaining B chunks ride along until their slice is reached.
        if (k < NS - 1) begin : g_skew
            logic [WIDTH-1:0] b_q;

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    b_q <= '0;
                end else if (adv) begin
                    b_q <= b_c[k] >> CHUNK;
                end
            end

            assign b_c[k+1] = b_q;
        end

        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        if (k == NS - 1) begin : g_flags
            logic ovf_q;

            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (m_c[k][CHUNK-1] ^ b_c[k][CHUNK-1] ^ ext[CHUNK-1]) ^ ext[CHUNK];
                end
            end

            assign Overflow = ovf_q;
        end
    end

    assign S         = m_c[NS];
    assign Cout      = c_c[NS];
    assign out_valid = v_c[NS];

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (WIDTH=16, CHUNK=4, four stages).
// Subtract vectors run only when PIPE_ADDSUB_SUB_EN is defined.
module tb_pipe_addsub;

    localparam int NS = 4;

    logic        Clock;
    logic        Resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
`ifdef PIPE_ADDSUB_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] S;
    logic        Cout;
    logic        Overflow;

    int n_cmp = 0;
    int n_err = 0;

    // Packed {Cout, Overflow, S} for A=i, B=0x1000*i, Cin=i[0], i=1..6
    logic [17:0] exp_str [6] = '{18'h01002, 18'h02002, 18'h03004,
                                 18'h04004, 18'h05006, 18'h06006};

    pipe_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef PIPE_ADDSUB_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One isolated operation; exp is {Cout, Overflow, S}. Entered and left at posedge+1.
    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic [17:0] exp);
        int waited;
        A         = a;
        B         = b;
        Cin       = ci;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 10) begin
            @(posedge Clock); #1;
            waited++;
        end
        chk({tag, "_lat"}, 32'(waited), 32'(NS - 1));
        chk({tag, "_res"}, 32'({Cout, Overflow, S}), 32'(exp));
        @(posedge Clock); #1;
    endtask

    initial begin
        int idx;
        int nout;
        int stale;

        Resetn    = 1'b0;
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        A         = 16'($urandom);
        B         = 16'($urandom);
        Cin       = 1'($urandom_range(0, 1));
`ifdef PIPE_ADDSUB_SUB_EN
        sub       = 1'($urandom_range(0, 1));
`endif
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_s",     32'(S),         32'd0);
        chk("rst_cout",  32'(Cout),      32'd0);
        chk("rst_ovf",   32'(Overflow),  32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);

        Resetn    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef PIPE_ADDSUB_SUB_EN
        sub       = 1'b0;
`endif
        @(posedge Clock); #1;

        run_one("carry_chunk", 16'h00FF, 16'h0001, 1'b0, 18'h00100);
        run_one("carry_out",   16'hFFFF, 16'h0001, 1'b0, 18'h20000);
        run_one("ovf_pos",     16'h7FFF, 16'h0001, 1'b0, 18'h18000);
        run_one("ovf_neg",     16'h8000, 16'hFFFF, 1'b0, 18'h37FFF);
        run_one("cin_only",    16'h0000, 16'h0000, 1'b1, 18'h00001);

`ifdef PIPE_ADDSUB_SUB_EN
        sub = 1'b1;
        run_one("sub_borrow", 16'h0005, 16'h0007, 1'b0, 18'h0FFFE);
        run_one("sub_ovf",    16'h8000, 16'h0001, 1'b1, 18'h37FFF);
        sub = 1'b0;
`endif

        // Back-to-back stream with a three-cycle consumer stall.
        idx  = 0;
        nout = 0;
        for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
            in_valid  = (idx < 6);
            A         = 16'(idx + 1);
            B         = 16'(32'h1000 * (idx + 1));
            Cin       = 1'((idx + 1) % 2);
            out_ready = !(cyc >= 4 && cyc <= 6);
            @(negedge Clock);
            if (cyc >= 4 && cyc <= 6) chk("stall_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (nout < 6) chk("stream_res", 32'({Cout, Overflow, S}), 32'(exp_str[nout]));
                else          chk("stream_extra", 32'(out_valid), 32'd0);
            end
            if (out_valid && out_ready) nout++;
            if (in_valid && in_ready) idx++;
            @(posedge Clock); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_cnt", 32'(nout), 32'd6);
        chk("stream_acc", 32'(idx),  32'd6);
        @(negedge Clock);
        chk("stream_drain", 32'(out_valid), 32'd0);
        @(posedge Clock); #1;

        // Reset while three operations are in flight.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A   = 16'(i + 1);
            B   = 16'h0000;
            Cin = 1'b0;
            @(posedge Clock); #1;
        end
        in_valid = 1'b0;
        @(posedge Clock); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_s",     32'(S),         32'h0001);
        Resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_s",     32'(S),         32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        stale  = 0;
        repeat (8) begin
            @(negedge Clock);
            if (out_valid) stale++;
        end
        chk("rst_stale", 32'(stale), 32'd0);
        @(posedge Clock); #1;
        run_one("post_rst", 16'h1234, 16'h1111, 1'b0, 18'h02345);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined ripple-carry adder (optionally adder/subtractor) for the DE2 exercise datapaths. It splits a WIDTH-bit add into CHUNK-bit ripple slices, one slice per pipeline stage, with a registered carry between stages. It accepts one operation per cycle and provides signed-overflow and carry-out flags. A valid/ready handshake lets it sit between switch/register front-ends and display or accumulator back-ends that may stall.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits summed per stage; number of stages NS = WIDTH/CHUNK (≥1).

- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present this cycle.
- in_ready  out  1  block accepts operands this cycle.
- A  in  WIDTH  operand A (two's complement or unsigned).
- B  in  WIDTH  operand B.
- Cin  in  1  carry into bit 0.
- sub  in  1  1 = A − B (present only with PIPE_ADDSUB_SUB_EN).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- S  out  WIDTH  sum/difference.
- Cout  out  1  carry out of bit WIDTH−1 (no-borrow when subtracting).
- Overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Global advance signal: adv = out_ready | ~out_valid; in_ready = adv.
- An operation is accepted when in_valid & in_ready. A bubble (in_valid=0 while adv) enters stage 1 as valid=0.
- Stage k (1..NS) sums bits [k·CHUNK−1 : (k−1)·CHUNK] using the carry registered by stage k−1 (stage 1 uses the effective Cin).
- Unconsumed upper operand chunks travel with the operation in skew registers. Completed lower sum chunks travel in deskew registers. All S bits of one operation appear together.
- Stage NS also registers Cout and Overflow for the same operation.
- When adv=0, every stage register, including the valid bits, holds its value. S, Cout and Overflow stay stable while out_valid=1 and out_ready=0.
- Bubbles are not collapsed: the pipeline advances or stalls as a whole.
- Results leave in acceptance order; none are dropped or duplicated.

## Timing
- Reset (Resetn=0, asynchronous): all valid bits, data, carry and flag registers go to 0. Outputs are out_valid=0, S=0, Cout=0, Overflow=0, in_ready=1.
- Latency: an operation accepted at edge t appears with out_valid=1 after edge t+NS−1, i.e. NS cycles, counting the accept edge, with no stalls in between. For NS=1 it is a single registered adder.
- Throughput: one operation per cycle while out_ready=1.
- Simultaneous accept and output handshake in the same cycle is legal and loses nothing.
- Resetn asserted mid-stream: all in-flight operations are discarded. Nothing is output after release until new operands are accepted.
- out_valid is never deasserted without out_ready=1 having been seen, or reset.

## Configuration
- PIPE_ADDSUB_SUB_EN defined: the sub port exists. sub is sampled with the operands and travels with them. When sub=1, the effective B is ~B and the effective carry-in is 1; Cin is ignored. Cout=1 means no borrow. Overflow uses the same MSB-carry rule.
- Not defined: no sub port, add only, effective carry-in = Cin.

## Test plan
Settings: WIDTH=16, CHUNK=4, so NS=4.
- Reset: hold Resetn=0 with random inputs. Required: out_valid=0, S=0x0000, Cout=0, Overflow=0, in_ready=1.
- Chunk carry: A=0x00FF, B=0x0001, Cin=0. Required after 4 cycles: S=0x0100, Cout=0, Overflow=0. Then A=0xFFFF, B=0x0001 gives S=0x0000, Cout=1, Overflow=0.
- Signed overflow: A=0x7FFF, B=0x0001 gives S=0x8000, Cout=0, Overflow=1. A=0x8000, B=0xFFFF gives S=0x7FFF, Cout=1, Overflow=1.
- Streaming with stall: 6 back-to-back operations (A=i, B=0x1000·i, Cin=i[0]) with out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 during the stall, held outputs stable, 6 results in order, none lost or duplicated.
- Subtract (macro defined): sub=1, A=0x0005, B=0x0007 gives S=0xFFFE, Cout=0, Overflow=0. A=0x8000, B=0x0001 gives S=0x7FFF, Cout=1, Overflow=1.
- Reset mid-stream: accept 3 operations, pulse Resetn low for 1 cycle. Required: out_valid=0 immediately and no stale results afterwards. The next operation (0x1234+0x1111) returns 0x2345 after 4 cycles.
